// File: rtl/tdc_measure_ctrl_pkg.sv
// Shared constants for the TDC measurement controller: tap/decoder sizing,
// FSM state encodings and result flag bit positions.
package tdc_measure_ctrl_pkg;

    localparam int NUM_TAPS   = 36;
    localparam int NUM_DECODE = 6;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_ARMED    = 3'd1;
    localparam state_t ST_RUN      = 3'd2;
    localparam state_t ST_WAIT_DEC = 3'd3;
    localparam state_t ST_CALC     = 3'd4;
    localparam state_t ST_OUT      = 3'd5;

    localparam int FLAG_OVF     = 0;
    localparam int FLAG_NEG     = 1;
    localparam int FLAG_TIMEOUT = 2;

endpackage

// File: rtl/tdc_measure_ctrl_coarse_counter.sv
// Saturating coarse cycle counter with synchronous clear; overflow flags the
// all-ones value.
module tdc_measure_ctrl_coarse_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             overflow
);

    assign overflow = &count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !overflow) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/tdc_measure_ctrl.sv
// TDC measurement sequencer: arm, coarse count, fine decoder triggering and
// interval combine. Optional macro TDC_CALIB_OFFSET_EN adds a static cal_offset.
//
// state    | meaning
// IDLE     | waiting for arm
// ARMED    | waiting for start_event
// RUN      | coarse counting until stop_event or saturation
// WAIT_DEC | collecting fine bins, watchdog running
// CALC     | combine coarse and fine into the interval
// OUT      | result presented until accepted
module tdc_measure_ctrl
    import tdc_measure_ctrl_pkg::*;
#(
    parameter int COARSE_W     = 16,
    parameter int TAPS_PER_CLK = NUM_TAPS,
    parameter int RES_W        = 24,
    parameter int DEC_TIMEOUT  = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arm,
    input  logic                  start_event,
    input  logic                  stop_event,
    output logic                  dec_go_start,
    output logic                  dec_go_stop,
    input  logic                  dec_fin_start,
    input  logic                  dec_fin_stop,
    input  logic [NUM_DECODE-1:0] dec_bin_start,
    input  logic [NUM_DECODE-1:0] dec_bin_stop,
    output logic                  busy,
    output logic                  res_valid,
    input  logic                  res_ready,
`ifdef TDC_CALIB_OFFSET_EN
    input  logic [RES_W-1:0]      cal_offset,
`endif
    output logic [RES_W-1:0]      res_interval,
    output logic [COARSE_W-1:0]   res_coarse,
    output logic [2:0]            res_flags
);

    localparam int CW   = RES_W + 2;
    localparam int WD_W = $clog2(DEC_TIMEOUT + 1);

    state_t                  state, state_nxt;
    logic [COARSE_W-1:0]     coarse;
    logic                    coarse_clr, coarse_en, coarse_ovf;
    logic [NUM_DECODE-1:0]   bin_start, bin_stop;
    logic                    got_start, got_stop, cap_start, cap_stop;
    logic                    both_done, timeout_hit, timed_out;
    logic [WD_W-1:0]         wdog;
    logic signed [CW-1:0]    calc_sum;
    logic                    calc_neg, calc_sat;
    logic [RES_W-1:0]        calc_interval;

    tdc_measure_ctrl_coarse_counter #(.WIDTH(COARSE_W)) u_coarse (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (coarse_clr),
        .enable   (coarse_en),
        .count    (coarse),
        .overflow (coarse_ovf)
    );

    assign busy       = (state != ST_IDLE);
    assign res_valid  = (state == ST_OUT);
    assign coarse_clr = (state == ST_ARMED) && start_event;
    assign coarse_en  = (state == ST_RUN);

    always_comb begin
        cap_start   = dec_fin_start && !got_start && (state == ST_RUN || state == ST_WAIT_DEC);
        cap_stop    = dec_fin_stop && !got_stop && (state == ST_RUN || state == ST_WAIT_DEC);
        // A finished pulse landing this cycle already counts toward leaving WAIT_DEC.
        both_done   = (got_start || cap_start) && (got_stop || cap_stop);
        timeout_hit = (state == ST_WAIT_DEC) && !both_done && (wdog == WD_W'(1));

        state_nxt = state;
        case (state)
            ST_IDLE:     if (arm) state_nxt = ST_ARMED;
            ST_ARMED: begin
                if (start_event && stop_event) state_nxt = ST_WAIT_DEC;
                else if (start_event)          state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (coarse_ovf)      state_nxt = ST_OUT;
                else if (stop_event) state_nxt = ST_WAIT_DEC;
            end
            ST_WAIT_DEC: if (both_done || timeout_hit) state_nxt = ST_CALC;
            ST_CALC:     state_nxt = ST_OUT;
            ST_OUT:      if (res_ready) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        calc_sum = $signed(CW'(coarse)) * $signed(CW'(TAPS_PER_CLK))
                 + $signed(CW'(bin_start)) - $signed(CW'(bin_stop))
`ifdef TDC_CALIB_OFFSET_EN
                 - $signed(CW'(cal_offset))
`endif
                 ;
        calc_neg = calc_sum[CW-1];
        calc_sat = !calc_neg && (|calc_sum[CW-2:RES_W]);
        if (calc_neg)      calc_interval = '0;
        else if (calc_sat) calc_interval = '1;
        else               calc_interval = calc_sum[RES_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            dec_go_start <= 1'b0;
            dec_go_stop  <= 1'b0;
            bin_start    <= '0;
            bin_stop     <= '0;
            got_start    <= 1'b0;
            got_stop     <= 1'b0;
            timed_out    <= 1'b0;
            wdog         <= '0;
            res_interval <= '0;
            res_coarse   <= '0;
            res_flags    <= '0;
        end else begin
            state        <= state_nxt;
            dec_go_start <= 1'b0;
            dec_go_stop  <= 1'b0;

            if (coarse_clr) begin
                dec_go_start <= 1'b1;
                dec_go_stop  <= stop_event;
                bin_start    <= '0;
                bin_stop     <= '0;
                got_start    <= 1'b0;
                got_stop     <= 1'b0;
                timed_out    <= 1'b0;
            end
            if (state == ST_RUN && !coarse_ovf && stop_event) dec_go_stop <= 1'b1;

            if (cap_start) begin
                bin_start <= dec_bin_start;
                got_start <= 1'b1;
            end
            if (cap_stop) begin
                bin_stop <= dec_bin_stop;
                got_stop <= 1'b1;
            end

            // Missing bins stay at their cleared value of zero on timeout.
            if (state_nxt == ST_WAIT_DEC && state != ST_WAIT_DEC) wdog <= WD_W'(DEC_TIMEOUT);
            else if (state == ST_WAIT_DEC && wdog != '0)         wdog <= wdog - WD_W'(1);
            if (timeout_hit) timed_out <= 1'b1;

            if (state == ST_RUN && coarse_ovf) begin
                res_interval       <= '1;
                res_coarse         <= coarse;
                res_flags          <= '0;
                res_flags[FLAG_OVF] <= 1'b1;
            end else if (state == ST_CALC) begin
                res_interval            <= calc_interval;
                res_coarse              <= coarse;
                res_flags               <= '0;
                res_flags[FLAG_TIMEOUT] <= timed_out;
                res_flags[FLAG_NEG]     <= calc_neg;
            end
        end
    end

endmodule
